moving_average_mc: RTL and testbench

Multi-channel, time-multiplexed boxcar moving averager. It is the parametrised successor of the single-channel strobe averager, and it sits between the sample front-end and the output formatter on the TinyTapeout wrapper. Each channel keeps a running sum: the new sample is added and the oldest is subtracted, so there is no per-sample window re-scan. Both ports use valid/ready handshakes, and the block supports optional rounding, warm-up tracking and synchronous clear.

---
 rtl/moving_avg_pkg.sv | 23 ++
 rtl/ma_history_ram.sv | 41 ++++
 rtl/moving_average_mc.sv | 208 ++++++++++++++++++++
 tb/tb_moving_average_mc.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moving_avg_pkg.sv
// Shared definitions for the multi-channel moving averager.
//   t_ma_state  : FSM state encoding (IDLE, FETCH, UPDATE, OUTPUT)
//   sum_width   : running-sum width needed for a window of 2^win_pow samples
//   chan_width  : channel index width, never narrower than one bit
package moving_avg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2,
        OUTPUT = 2'd3
    } t_ma_state;

    // Sum of 2^win_pow unsigned data_w-bit samples fits in data_w+win_pow bits.
    function automatic int sum_width(input int data_w, input int win_pow);
        return data_w + win_pow;
    endfunction

    function automatic int chan_width(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/ma_history_ram.sv
// Sample history for all channels: DEPTH x DATA_W register file.
// Ports:
//   clk        : clock
//   i_rd_en    : read enable; o_rd_data updates on the next rising edge
//   i_rd_addr  : read address
//   o_rd_data  : registered read data
//   i_wr_en    : write enable
//   i_wr_addr  : write address
//   i_wr_data  : write data
// Contents are not reset: the owner only consumes entries it has written.
module ma_history_ram
    import moving_avg_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/moving_average_mc.sv
// Multi-channel, time-multiplexed boxcar moving averager.
// Each channel keeps a running sum over its last N = 2^WIN_POW samples:
// the new sample is added and the sample leaving the window is subtracted.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   i_clear           : synchronous clear of all channel state
//   i_in_valid/o_in_ready, i_in_chan, i_in_data : sample input
//   o_out_valid/i_out_ready, o_out_chan, o_out_data, o_out_primed : average
//   o_err             : one-cycle pulse after a sample with an invalid channel
//   o_state           : current FSM state (t_ma_state encoding)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload until that edge;
// o_out_* stay stable while o_out_valid is high and i_out_ready is low.
module moving_average_mc
    import moving_avg_pkg::*;
#(
    parameter int  DATA_W   = 10,
    parameter int  WIN_POW  = 2,
    parameter int  CHANNELS = 4,
    parameter int  ROUND    = 0,
    localparam int CH_W     = chan_width(CHANNELS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [CH_W-1:0]   i_in_chan,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CH_W-1:0]   o_out_chan,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_primed,
    output logic              o_err,
    output logic [1:0]        o_state
);

    localparam int N      = 1 << WIN_POW;
    localparam int SUM_W  = sum_width(DATA_W, WIN_POW);
    localparam int PTR_W  = (WIN_POW > 0) ? WIN_POW : 1;
    localparam int CNT_W  = WIN_POW + 1;
    localparam int DEPTH  = CHANNELS * N;
    localparam int ADDR_W = chan_width(DEPTH);

    // Rounding offset is half an LSB of the result; N/2 is 0 when N == 1.
    localparam logic [SUM_W:0] HALF_V   = (ROUND != 0) ? (SUM_W+1)'(N / 2) : '0;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);

    t_ma_state r_state;
    t_ma_state w_state_next;

    logic [CH_W-1:0]   r_chan;
    logic [DATA_W-1:0] r_data;

    logic [SUM_W-1:0]  r_sum [CHANNELS];
    logic [PTR_W-1:0]  r_ptr [CHANNELS];
    logic [CNT_W-1:0]  r_cnt [CHANNELS];

    logic [DATA_W-1:0] r_out_data;
    logic [CH_W-1:0]   r_out_chan;
    logic              r_out_primed;
    logic              r_err;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_bad_accept;
    logic              w_bad_chan;

    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_ram_q;
    logic [SUM_W-1:0]  w_cur_sum;
    logic [PTR_W-1:0]  w_cur_ptr;
    logic [CNT_W-1:0]  w_cur_cnt;
    logic              w_full;
    logic [DATA_W-1:0] w_oldest;
    logic [SUM_W-1:0]  w_sum_new;
    logic [PTR_W-1:0]  w_ptr_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [DATA_W-1:0] w_avg;

    // Compared at 32 bits so the check stays meaningful when CHANNELS
    // fills the whole index range.
    assign w_bad_chan = (32'(i_in_chan) >= 32'(CHANNELS));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_bad_accept = 1'b0;
        // clear wins over an input handshake, so ready drops while it is high.
        w_in_ready   = (r_state == IDLE) && !i_clear;
        if (i_clear) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        if (w_bad_chan) begin
                            // Taken off the bus and dropped; FSM stays idle.
                            w_bad_accept = 1'b1;
                        end else begin
                            w_accept     = 1'b1;
                            w_state_next = FETCH;
                        end
                    end
                end
                FETCH:   w_state_next = UPDATE;
                UPDATE:  w_state_next = OUTPUT;
                OUTPUT: begin
                    if (i_out_ready) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ datapath
    assign w_cur_sum = r_sum[r_chan];
    assign w_cur_ptr = r_ptr[r_chan];
    assign w_cur_cnt = r_cnt[r_chan];

    // Read the slot about to be overwritten during FETCH; the registered
    // read data is valid in UPDATE, which then writes the same slot.
    assign w_addr = (ADDR_W'(r_chan) << WIN_POW) | ADDR_W'(w_cur_ptr);

    ma_history_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_history (
        .clk       (clk),
        .i_rd_en   (r_state == FETCH),
        .i_rd_addr (w_addr),
        .o_rd_data (w_ram_q),
        .i_wr_en   ((r_state == UPDATE) && !i_clear),
        .i_wr_addr (w_addr),
        .i_wr_data (r_data)
    );

    // Until the window has filled, the slot holds nothing of this run
    // (stale data from before a clear, or uninitialised), so treat it as 0.
    assign w_full     = (w_cur_cnt == CNT_FULL);
    assign w_oldest   = w_full ? w_ram_q : '0;
    assign w_sum_new  = w_cur_sum + SUM_W'(r_data) - SUM_W'(w_oldest);
    assign w_cnt_next = w_full ? w_cur_cnt : w_cur_cnt + CNT_W'(1);
    assign w_ptr_next = (w_cur_ptr == PTR_LAST) ? '0 : w_cur_ptr + PTR_W'(1);
    // One extra bit keeps the rounding add exact; the shifted result always
    // fits DATA_W bits.
    assign w_avg      = DATA_W'(({1'b0, w_sum_new} + HALF_V) >> WIN_POW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_sum[c] <= '0;
                r_ptr[c] <= '0;
                r_cnt[c] <= '0;
            end
            r_chan       <= '0;
            r_data       <= '0;
            r_out_data   <= '0;
            r_out_chan   <= '0;
            r_out_primed <= 1'b0;
            r_err        <= 1'b0;
        end else if (i_clear) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_sum[c] <= '0;
                r_ptr[c] <= '0;
                r_cnt[c] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            r_err <= w_bad_accept;
            if (w_accept) begin
                r_chan <= i_in_chan;
                r_data <= i_in_data;
            end
            if (r_state == UPDATE) begin
                r_sum[r_chan] <= w_sum_new;
                r_ptr[r_chan] <= w_ptr_next;
                r_cnt[r_chan] <= w_cnt_next;
                r_out_data    <= w_avg;
                r_out_chan    <= r_chan;
                r_out_primed  <= (w_cnt_next == CNT_FULL);
            end
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_out_valid  = (r_state == OUTPUT);
    assign o_out_chan   = r_out_chan;
    assign o_out_data   = r_out_data;
    assign o_out_primed = r_out_primed;
    assign o_err        = r_err;
    assign o_state      = r_state;

endmodule

// File: tb/tb_moving_average_mc.sv
// Bench for moving_average_mc. Three instances share clock and reset:
//   0 : defaults (N=4, 4 channels, truncate)
//   1 : ROUND=1
//   2 : CHANNELS=3
module tb_moving_average_mc;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear     [NI];
    logic       in_valid  [NI];
    logic       out_ready [NI];
    logic [1:0] in_chan   [NI];
    logic [9:0] in_data   [NI];
    logic       in_ready  [NI];
    logic       out_valid [NI];
    logic       out_primed[NI];
    logic       err       [NI];
    logic [1:0] out_chan  [NI];
    logic [1:0] st        [NI];
    logic [9:0] out_data  [NI];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  [NI];
    logic ov_prev [NI];

    // Expected output records {chan[1:0], data[9:0], primed}.
    logic [12:0] exp_q [NI][$];

    typedef struct {
        int inst;
        int ch;
        int d;
        int ed;
        int ep;
    } vec_t;

    // ------------------------------------------------ clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------- DUTs
    moving_average_mc u_dut0 (
        .clk(clk), .reset(reset), .i_clear(clear[0]),
        .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
        .i_in_chan(in_chan[0]), .i_in_data(in_data[0]),
        .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]),
        .o_out_chan(out_chan[0]), .o_out_data(out_data[0]),
        .o_out_primed(out_primed[0]), .o_err(err[0]), .o_state(st[0])
    );

    moving_average_mc #(.ROUND(1)) u_dut1 (
        .clk(clk), .reset(reset), .i_clear(clear[1]),
        .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
        .i_in_chan(in_chan[1]), .i_in_data(in_data[1]),
        .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]),
        .o_out_chan(out_chan[1]), .o_out_data(out_data[1]),
        .o_out_primed(out_primed[1]), .o_err(err[1]), .o_state(st[1])
    );

    moving_average_mc #(.CHANNELS(3)) u_dut2 (
        .clk(clk), .reset(reset), .i_clear(clear[2]),
        .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]),
        .i_in_chan(in_chan[2]), .i_in_data(in_data[2]),
        .o_out_valid(out_valid[2]), .i_out_ready(out_ready[2]),
        .o_out_chan(out_chan[2]), .o_out_data(out_data[2]),
        .o_out_primed(out_primed[2]), .o_err(err[2]), .o_state(st[2])
    );

    // ---------------------------------------------------------- checker
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------- scoreboard
    // Sampled on the falling edge: a record is consumed when valid and
    // ready are both high, i.e. just before the transfer edge.
    always @(negedge clk) begin : monitor
        logic [12:0] e;
        if (!reset) begin
            for (int i = 0; i < NI; i++) begin
                if (out_valid[i] && !ov_prev[i]) begin
                    check("latency", cyc - acc_cyc[i] + 1, 3);
                end
                if (out_valid[i] && out_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check("out_valid_unexpected", int'(out_valid[i]), 0);
                    end else begin
                        e = exp_q[i].pop_front();
                        check("out_chan",   int'(out_chan[i]),   int'(e[12:11]));
                        check("out_data",   int'(out_data[i]),   int'(e[10:1]));
                        check("out_primed", int'(out_primed[i]), int'(e[0]));
                    end
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            ov_prev[i] = out_valid[i];
        end
    end

    // ---------------------------------------------------------- drivers
    task automatic send(input int i, input int ch, input int d,
                        input bit push, input int ed, input int ep);
        int t;
        logic [1:0] c2;
        logic [9:0] d2;
        logic [9:0] e2;
        c2 = 2'(ch);
        d2 = 10'(d);
        e2 = 10'(ed);
        @(posedge clk); #1;
        in_valid[i] = 1'b1;
        in_chan[i]  = c2;
        in_data[i]  = d2;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready[i] && t < 100);
        if (!in_ready[i]) begin
            check("accept_timeout", int'(in_ready[i]), 1);
        end
        acc_cyc[i] = cyc + 1;
        if (push) begin
            exp_q[i].push_back({c2, e2, 1'(ep)});
        end
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int t;
        t = 0;
        while ((exp_q[i].size() != 0 || out_valid[i]) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", exp_q[i].size(), 0);
    endtask

    // ---------------------------------------------------------- stimulus
    initial begin
        vec_t tbl [18];
        int t;

        // ch0 window fill, then window slide.
        tbl[0]  = '{0, 0, 100,   25, 0};
        tbl[1]  = '{0, 0, 200,   75, 0};
        tbl[2]  = '{0, 0, 300,  150, 0};
        tbl[3]  = '{0, 0, 400,  250, 1};
        tbl[4]  = '{0, 0, 500,  350, 1};
        // ch1 and ch2 interleaved, both starting empty.
        tbl[5]  = '{0, 1, 1023, 255, 0};
        tbl[6]  = '{0, 2, 8,      2, 0};
        tbl[7]  = '{0, 1, 1023, 511, 0};
        tbl[8]  = '{0, 2, 8,      4, 0};
        tbl[9]  = '{0, 1, 1023, 767, 0};
        tbl[10] = '{0, 2, 8,      6, 0};
        tbl[11] = '{0, 1, 1023,1023, 1};
        tbl[12] = '{0, 2, 8,      8, 1};
        // ch0 window is still {200,300,400,500}: (1400 + 4 - 200) / 4.
        tbl[13] = '{0, 0, 4,    301, 1};
        // Round-half-up: sums 2, 3, 9, 10 -> (sum + 2) >> 2.
        tbl[14] = '{1, 0, 2,      1, 0};
        tbl[15] = '{1, 0, 1,      1, 0};
        tbl[16] = '{1, 0, 6,      2, 0};
        tbl[17] = '{1, 0, 1,      3, 1};

        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            clear[i]     = 1'b0;
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            in_chan[i]   = '0;
            in_data[i]   = '0;
            acc_cyc[i]   = 0;
            ov_prev[i]   = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_in_ready",   int'(in_ready[i]),   1);
            check("rst_out_valid",  int'(out_valid[i]),  0);
            check("rst_out_chan",   int'(out_chan[i]),   0);
            check("rst_out_data",   int'(out_data[i]),   0);
            check("rst_out_primed", int'(out_primed[i]), 0);
            check("rst_err",        int'(err[i]),        0);
            check("rst_state",      int'(st[i]),         0);
        end
        reset = 1'b0;

        // Table-driven vectors.
        for (int k = 0; k < 18; k++) begin
            send(tbl[k].inst, tbl[k].ch, tbl[k].d, 1'b1, tbl[k].ed, tbl[k].ep);
        end
        drain(0);
        drain(1);

        // Backpressure on instance 0, ch3 starting empty.
        out_ready[0] = 1'b0;
        send(0, 3, 40, 1'b1, 10, 0);
        t = 0;
        while (!out_valid[0] && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid", int'(out_valid[0]), 1);
        in_valid[0] = 1'b1;
        in_chan[0]  = 2'd3;
        in_data[0]  = 10'd80;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_valid", int'(out_valid[0]), 1);
            check("bp_hold_data",  int'(out_data[0]),  10);
            check("bp_hold_chan",  int'(out_chan[0]),  3);
            check("bp_in_ready",   int'(in_ready[0]),  0);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready[0] && t < 20);
        check("bp_pending_accept_cycle", t, 2);
        acc_cyc[0] = cyc + 1;
        exp_q[0].push_back({2'd3, 10'd30, 1'b0});
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        drain(0);

        // Clear during FETCH. ch3 history is {40, 80} before these three.
        send(0, 3, 400, 1'b1, 130, 0);
        send(0, 3, 400, 1'b1, 230, 1);
        send(0, 3, 400, 1'b1, 320, 1);
        drain(0);
        @(posedge clk); #1;
        in_valid[0] = 1'b1;
        in_chan[0]  = 2'd3;
        in_data[0]  = 10'd400;
        @(negedge clk);
        check("clr_accept_ready", int'(in_ready[0]), 1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("clr_in_fetch", int'(st[0]), 1);
        clear[0] = 1'b1;
        #1;
        check("clr_blocks_ready", int'(in_ready[0]), 0);
        @(posedge clk); #1;
        clear[0] = 1'b0;
        check("clr_state_idle", int'(st[0]), 0);
        repeat (6) begin
            @(negedge clk);
            check("clr_no_out_valid", int'(out_valid[0]), 0);
        end
        send(0, 3, 400, 1'b1, 100, 0);
        send(0, 0, 4,   1'b1, 1,   0);
        drain(0);

        // Invalid channel on the 3-channel instance.
        send(2, 1, 100, 1'b1, 25, 0);
        drain(2);
        @(posedge clk); #1;
        in_valid[2] = 1'b1;
        in_chan[2]  = 2'd3;
        in_data[2]  = 10'd5;
        @(negedge clk);
        check("inv_in_ready", int'(in_ready[2]), 1);
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        @(negedge clk);
        check("inv_err_high", int'(err[2]), 1);
        check("inv_state_idle", int'(st[2]), 0);
        @(negedge clk);
        check("inv_err_pulse_end", int'(err[2]), 0);
        repeat (4) begin
            @(negedge clk);
            check("inv_no_out_valid", int'(out_valid[2]), 0);
        end

        // Reset while in UPDATE.
        @(posedge clk); #1;
        in_valid[2] = 1'b1;
        in_chan[2]  = 2'd0;
        in_data[2]  = 10'd40;
        @(negedge clk);
        check("rmid_accept_ready", int'(in_ready[2]), 1);
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        @(posedge clk); #1;
        check("rmid_in_update", int'(st[2]), 2);
        reset = 1'b1;
        #1;
        check("rmid_in_ready",   int'(in_ready[2]),   1);
        check("rmid_out_valid",  int'(out_valid[2]),  0);
        check("rmid_out_chan",   int'(out_chan[2]),   0);
        check("rmid_out_data",   int'(out_data[2]),   0);
        check("rmid_out_primed", int'(out_primed[2]), 0);
        check("rmid_err",        int'(err[2]),        0);
        check("rmid_state",      int'(st[2]),         0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        send(2, 0, 40, 1'b1, 10, 0);
        drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
